// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with a
// mem_ready handshake, wait timeout and retired-instruction counter. Define ILLEGAL_TRAP_EN to trap illegal opcodes.
module mc_control_unit #(
  parameter int XLEN    = 64,
  parameter int MEM_TMO = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemSize,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             trap
`endif
);

  localparam int TW = $clog2(MEM_TMO + 1);
  localparam logic [TW-1:0] TMO_VAL  = TW'(MEM_TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TMO - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LD    = 6'b110111;
  localparam logic [5:0] OP_SD    = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ADDI, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWR, S_MEMWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          is_rtype, is_load, is_dword, is_bne;

  logic   is_wait, tmo, done, last_wait, retire;
  state_t dec_state;
  logic   dec_load, dec_dword;

  // A wait state that has used up its budget spends one cycle aborting: requests drop, mem_ready is ignored.
  assign is_wait   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign tmo       = is_wait && (wait_cnt == TMO_VAL);
  assign done      = is_wait && !tmo && mem_ready;
  assign last_wait = is_wait && !tmo && !mem_ready && (wait_cnt == TMO_LAST);
  assign retire    = (state == S_ALUWB) || (state == S_MEMWB) || (state == S_BRANCH) ||
                     (state == S_JUMP) || ((state == S_MEMWR) && done);

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_state = ILLEGAL_NEXT;
    dec_load  = 1'b0;
    dec_dword = 1'b0;
    case (opcode)
      OP_RTYPE:       dec_state = S_EXEC;
      OP_ADDI:        dec_state = S_ADDI;
      OP_LW:          begin dec_state = S_MEMADR; dec_load = 1'b1; end
      OP_SW:          dec_state = S_MEMADR;
      OP_LD:
        if (XLEN == 64) begin
          dec_state = S_MEMADR;
          dec_load  = 1'b1;
          dec_dword = 1'b1;
        end
      OP_SD:
        if (XLEN == 64) begin
          dec_state = S_MEMADR;
          dec_dword = 1'b1;
        end
      OP_BEQ, OP_BNE: dec_state = S_BRANCH;
      OP_J:           dec_state = S_JUMP;
      default:        dec_state = ILLEGAL_NEXT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      is_rtype <= 1'b0;
      is_load  <= 1'b0;
      is_dword <= 1'b0;
      is_bne   <= 1'b0;
      mem_err  <= 1'b0;
      retired  <= '0;
    end else begin
      mem_err  <= last_wait;
      wait_cnt <= (is_wait && !mem_ready && !tmo) ? wait_cnt + TW'(1) : '0;
      if (retire) retired <= retired + CNT_W'(1);
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (done) state <= S_DECODE;
        S_DECODE: begin
          state    <= dec_state;
          is_rtype <= (opcode == OP_RTYPE);
          is_load  <= dec_load;
          is_dword <= dec_dword;
          is_bne   <= (opcode == OP_BNE);
        end
        S_EXEC, S_ADDI: state <= S_ALUWB;
        S_MEMADR: state <= is_load ? S_MEMRD : S_MEMWR;
        S_MEMRD:
          if (tmo)       state <= S_FETCH;
          else if (done) state <= S_MEMWB;
        S_MEMWR:  if (tmo || done) state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemSize  = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
`ifdef ILLEGAL_TRAP_EN
    trap     = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        MemRead = !tmo;
        ALUSrcB = 2'b01;
        IRWrite = done;
        PCWrite = done;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ADDI, S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        MemSize = (state == S_MEMADR) && is_dword;
      end
      S_ALUWB: begin
        RegDst   = is_rtype;
        RegWrite = 1'b1;
      end
      S_MEMRD: begin
        MemRead = !tmo;
        IorD    = 1'b1;
        MemSize = is_dword;
      end
      S_MEMWR: begin
        MemWrite = !tmo;
        IorD     = 1'b1;
        MemSize  = is_dword;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        MemSize  = is_dword;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCWrite = is_bne ? !zero : zero;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        trap    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
